mem_access_unit: RTL

//   MEM stage of the 5-stage MIPS pipeline. It sits between the EX/MEM register and MEM_WB.
//   It runs lw/sw over a req/ack data-memory port and stalls the pipeline until the access

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The master side issues requests; the slave side returns ack and load data.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS pipeline: runs lw/sw over the req/ack data-memory bus,
// stalls until the access completes, and squashes misaligned or timed-out accesses.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [1:0]          control_wb_in,
  input  logic [31:0]         alu_result_in,
  input  logic [31:0]         write_data_in,
  input  logic [4:0]          write_reg_in,
  mem_access_unit_if.master   dmem,
  output logic                stall,
  output logic [1:0]          control_wb_out,
  output logic [31:0]         read_data_out,
  output logic [31:0]         alu_result_out,
  output logic [4:0]          write_reg_out,
  output logic                err_misalign,
  output logic                err_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             req_r, we_r;
  logic [31:0]      addr_r, wdata_r;
  logic [1:0]       hold_wb_r;
  logic [31:0]      hold_alu_r;
  logic [4:0]       hold_reg_r;
  logic             hold_load_r;
  logic             issue_s, finish_s;
  logic             stall_s, mis_s, tmo_s;
  logic [1:0]       cwb_s;
  logic [31:0]      rd_s, alu_s;
  logic [4:0]       wreg_s;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Next-state, counter and MEM_WB-facing values for the current cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    issue_s     = 1'b0;
    finish_s    = 1'b0;
    stall_s     = 1'b0;
    mis_s       = 1'b0;
    tmo_s       = 1'b0;
    cwb_s       = control_wb_in;
    rd_s        = 32'd0;
    alu_s       = alu_result_in;
    wreg_s      = write_reg_in;
    case (state_r)
      ST_IDLE: begin
        if (mem_read_in || mem_write_in) begin
          if (is_misaligned(alu_result_in)) begin
            mis_s = 1'b1;
            cwb_s = 2'b00;
          end else begin
            stall_s     = 1'b1;
            issue_s     = 1'b1;
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = '0;
          end
        end else begin
          cwb_s = control_wb_in;
        end
      end
      ST_WAIT: begin
        cwb_s  = hold_wb_r;
        alu_s  = hold_alu_r;
        wreg_s = hold_reg_r;
        // A late ack on the final counted cycle still completes normally.
        if (dmem.dmem_ack) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
          rd_s        = hold_load_r ? dmem.dmem_rdata : 32'd0;
        end else if (cnt_r == CNT_LAST) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
          cwb_s       = 2'b00;
          tmo_s       = 1'b1;
        end else begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, combinational paths included.
  always_comb begin
    if (reset) begin
      stall          = stall_s;
      control_wb_out = cwb_s;
      read_data_out  = rd_s;
      alu_result_out = alu_s;
      write_reg_out  = wreg_s;
      err_misalign   = mis_s;
      err_timeout    = tmo_s;
    end else begin
      stall          = 1'b0;
      control_wb_out = 2'b00;
      read_data_out  = 32'd0;
      alu_result_out = 32'd0;
      write_reg_out  = 5'd0;
      err_misalign   = 1'b0;
      err_timeout    = 1'b0;
    end
  end

  // State and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Memory-bus request registers: loaded on issue, dropped when the access finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else if (issue_s) begin
      req_r   <= 1'b1;
      we_r    <= mem_write_in;
      addr_r  <= alu_result_in;
      wdata_r <= write_data_in;
    end else if (finish_s) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      req_r   <= req_r;
      we_r    <= we_r;
    end
  end

  // Holding registers feed MEM_WB while the upstream fields may change under the stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_wb_r   <= 2'b00;
      hold_alu_r  <= 32'd0;
      hold_reg_r  <= 5'd0;
      hold_load_r <= 1'b0;
    end else if (issue_s) begin
      hold_wb_r   <= control_wb_in;
      hold_alu_r  <= alu_result_in;
      hold_reg_r  <= write_reg_in;
      hold_load_r <= mem_read_in;
    end else begin
      hold_wb_r   <= hold_wb_r;
      hold_alu_r  <= hold_alu_r;
      hold_reg_r  <= hold_reg_r;
      hold_load_r <= hold_load_r;
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;

endmodule
